dmem_arbiter: RTL

Shared data-memory controller placed between two requesters and the single word-wide data memory: port 0 is the core load/store unit, port 1 is the debug/DMA loader. It arbitrates round-robin, sequences each access through a three-state FSM, generates byte-lane write enables for SB/SH/SW, and extracts and extends LB/LH/LW/LBU/LHU read data. The memory samples on a clock edge with one-cycle read latency.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lane_unit.sv | 87 ++++++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and constants for the data-memory arbiter slice.
//           Provides the RISC-V load/store funct3 size codes, the controller
//           state encoding, the latched request record and a funct3
//           legality helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RISC-V load/store size codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request as latched on the handshake; addr is zero-extended to 32 bits
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  // Stores accept B/H/W only; loads additionally accept BU/HU
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module  : dmem_lane_unit
// Purpose : Purely combinational byte-lane steering for a 32-bit data memory.
//           Produces byte write enables and replicated store data, extracts
//           and sign/zero-extends load data, and flags bad accesses.
// Ports   : i_we        - 1 = store, 0 = load
//           i_funct3    - RISC-V size code
//           i_off       - byte offset within the word (addr[1:0])
//           i_wdata     - right-aligned store data
//           i_mem_rdata - raw memory word
//           o_wr        - byte write enables (0 for loads and errors)
//           o_wdata     - lane-replicated store data
//           o_rdata     - extended load result (0 for stores and errors)
//           o_err       - illegal funct3 (or misaligned, see macro)
// Config  : DMEM_ARB_MISALIGN_CHECK_EN - when defined, misaligned halfword
//           and word accesses are flagged as errors and suppressed.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_wr,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        w_misalign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_misalign = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    // funct3[1:0]==01 covers both H and HU
    w_misalign = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                 ((i_funct3 == F3_W) && (i_off != 2'b00));
`endif
    o_err = !f3_legal(i_we, i_funct3) || w_misalign;

    o_wr    = 4'b0000;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_wr    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        // Halfword lane chosen by addr[1] only; addr[0] is ignored here
        o_wr    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_wr = 4'b1111;
      end
      default: begin
        o_wr = 4'b0000;
      end
    endcase
    if (!i_we || o_err) begin
      o_wr = 4'b0000;
    end

    w_byte  = i_mem_rdata[{i_off, 3'b000} +: 8];
    w_half  = i_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    o_rdata = 32'h0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      F3_W:    o_rdata = i_mem_rdata;
      default: o_rdata = 32'h0;
    endcase
    if (i_we || o_err) begin
      o_rdata = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Two-port round-robin controller in front of a single word-wide
//           data memory (1-cycle read latency). Each access runs
//           IDLE -> ACCESS -> RESP, so one access completes every 3 cycles.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           req_valid/ready     - per-port handshake (ready only in IDLE)
//           req_we, req_addrN, req_wdataN, req_funct3_N - request fields
//           resp_valid          - one-cycle per-port response strobe
//           resp_rdata/resp_err - response data / error, qualified by
//                                 resp_valid
//           mem_addr/wdata/wr   - memory word address, store data, byte
//                                 enables
//           mem_rdata           - memory read data
// Config  : DMEM_ARB_MISALIGN_CHECK_EN - enables misalignment errors
//           (handled in dmem_lane_unit).
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [DM_ADDRESS-1:0] req_addr0,
  input  logic [DM_ADDRESS-1:0] req_addr1,
  input  logic [DATA_W-1:0]     req_wdata0,
  input  logic [DATA_W-1:0]     req_wdata1,
  input  logic [2:0]            req_funct3_0,
  input  logic [2:0]            req_funct3_1,
  output logic [1:0]            resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  req_t        r_req;
  req_t        w_sel_req;
  logic        r_port;
  logic        r_last_grant;
  logic        w_grant;
  logic        w_hs;
  logic [3:0]  w_lane_wr;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_lane_rdata;
  logic        w_lane_err;

  dmem_lane_unit u_lane (
    .i_we        (r_req.we),
    .i_funct3    (r_req.funct3),
    .i_off       (r_req.addr[1:0]),
    .i_wdata     (r_req.wdata),
    .i_mem_rdata (mem_rdata),
    .o_wr        (w_lane_wr),
    .o_wdata     (w_lane_wdata),
    .o_rdata     (w_lane_rdata),
    .o_err       (w_lane_err)
  );

  // Word address is held from the latched request so the memory sees it in
  // ACCESS and the read word lines up with RESP.
  assign mem_addr  = {r_req.addr[31:2], 2'b00};
  assign mem_wdata = w_lane_wdata;

  always_comb begin
    // Single requester wins outright; on a tie the port not granted last wins
    case (req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      default: w_grant = ~r_last_grant;
    endcase

    w_sel_req.we     = req_we[w_grant];
    w_sel_req.addr   = w_grant ? {{(32-DM_ADDRESS){1'b0}}, req_addr1}
                               : {{(32-DM_ADDRESS){1'b0}}, req_addr0};
    w_sel_req.wdata  = w_grant ? req_wdata1 : req_wdata0;
    w_sel_req.funct3 = w_grant ? req_funct3_1 : req_funct3_0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_wr      = 4'b0000;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[w_grant] = 1'b1;
          w_hs               = 1'b1;
          w_state_nxt        = ACCESS;
        end
      end
      ACCESS: begin
        mem_wr      = w_lane_wr;
        w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid[r_port] = 1'b1;
        resp_rdata         = w_lane_rdata;
        resp_err           = w_lane_err;
        w_state_nxt        = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_req        <= w_sel_req;
        r_port       <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

endmodule
`default_nettype wire
